// File: rtl/axi4_lite_subordinate_if.sv
// Shared RV32 types plus the AXI4-Lite bundle used between the
// interconnect and a memory-mapped peripheral responder.
package rv32;
  localparam int XLEN = 32;
  localparam int DEFAULT_AXI_ADDR_WIDTH = 32;
  localparam int DEFAULT_AXI_TIMEOUT = 16;
  typedef logic [XLEN-1:0] word;
endpackage

interface axi4_lite
  import rv32::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH
) ();
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  word                   rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  word                   wdata;
  logic [XLEN/8-1:0]     wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport manager (
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready,
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport subordinate (
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready,
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi4_lite_subordinate.sv
// AXI4-Lite responder: one decoded region, one local access at a
// time with timeout, OKAY/SLVERR/DECERR responses.
module axi4_lite_subordinate
  import rv32::*;
#(
  parameter int                    ADDR_WIDTH  = DEFAULT_AXI_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter longint unsigned       REGION_SIZE = 'h1000,
  parameter int                    TIMEOUT     = DEFAULT_AXI_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi4_lite.subordinate         axi_s,
  output logic                  rd_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output word                   wr_data,
  output logic [XLEN/8-1:0]     wr_strobe,
  input  word                   rd_data,
  input  logic                  ready,
  input  logic                  fault
);

  localparam int TW = $clog2(TIMEOUT + 1) + 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_ACCESS = 3'd1;
  localparam logic [2:0] WR_ACCESS = 3'd2;
  localparam logic [2:0] R_RESP    = 3'd3;
  localparam logic [2:0] B_RESP    = 3'd4;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  logic [2:0]            state;
  logic                  ar_full;
  logic                  aw_full;
  logic                  w_full;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [ADDR_WIDTH-1:0] aw_addr;
  word                   w_data;
  logic [XLEN/8-1:0]     w_strb;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [TW-1:0]         timer;
  logic                  last_was_write;
  logic [1:0]            resp;
  word                   rdata_q;
  logic                  pick_rd;
  logic                  pick_wr;
  logic                  timed_out;
  logic                  unused_prot;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (64'(off) < REGION_SIZE);
  endfunction

  // Alternate on contention; otherwise take whatever is ready.
  assign pick_wr = aw_full & w_full & (~ar_full | ~last_was_write);
  assign pick_rd = ar_full & ~pick_wr;
  assign timed_out = ~ready & (timer >= TW'(TIMEOUT));
  assign unused_prot = ^{axi_s.arprot, axi_s.awprot};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      ar_full        <= 1'b0;
      aw_full        <= 1'b0;
      w_full         <= 1'b0;
      ar_addr        <= '0;
      aw_addr        <= '0;
      w_data         <= '0;
      w_strb         <= '0;
      acc_addr       <= '0;
      timer          <= '0;
      last_was_write <= 1'b1;
      resp           <= OKAY;
      rdata_q        <= '0;
    end else begin
      if (axi_s.arvalid && !ar_full) begin
        ar_full <= 1'b1;
        ar_addr <= axi_s.araddr;
      end
      if (axi_s.awvalid && !aw_full) begin
        aw_full <= 1'b1;
        aw_addr <= axi_s.awaddr;
      end
      if (axi_s.wvalid && !w_full) begin
        w_full <= 1'b1;
        w_data <= axi_s.wdata;
        w_strb <= axi_s.wstrb;
      end
      case (state)
        IDLE: begin
          timer <= '0;
          if (pick_rd) begin
            last_was_write <= 1'b0;
            acc_addr       <= ar_addr - BASE_ADDR;
            if (in_range(ar_addr)) begin
              state <= RD_ACCESS;
            end else begin
              resp    <= DECERR;
              rdata_q <= '0;
              state   <= R_RESP;
            end
          end else if (pick_wr) begin
            last_was_write <= 1'b1;
            acc_addr       <= aw_addr - BASE_ADDR;
            if (in_range(aw_addr)) begin
              state <= WR_ACCESS;
            end else begin
              resp  <= DECERR;
              state <= B_RESP;
            end
          end
        end
        RD_ACCESS: begin
          timer <= timer + TW'(1);
          if (ready) begin
            rdata_q <= rd_data;
            resp    <= fault ? SLVERR : OKAY;
            state   <= R_RESP;
          end else if (timed_out) begin
            rdata_q <= '0;
            resp    <= SLVERR;
            state   <= R_RESP;
          end
        end
        WR_ACCESS: begin
          timer <= timer + TW'(1);
          if (ready) begin
            resp  <= fault ? SLVERR : OKAY;
            state <= B_RESP;
          end else if (timed_out) begin
            resp  <= SLVERR;
            state <= B_RESP;
          end
        end
        R_RESP: begin
          if (axi_s.rready) begin
            ar_full <= 1'b0;
            state   <= IDLE;
          end
        end
        B_RESP: begin
          if (axi_s.bready) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything is forced low while reset is asserted, edge or not.
  assign axi_s.arready = rst_n & ~ar_full;
  assign axi_s.awready = rst_n & ~aw_full;
  assign axi_s.wready  = rst_n & ~w_full;
  assign axi_s.rvalid  = rst_n & (state == R_RESP);
  assign axi_s.bvalid  = rst_n & (state == B_RESP);
  assign axi_s.rdata   = rst_n ? rdata_q : '0;
  assign axi_s.rresp   = rst_n ? resp : OKAY;
  assign axi_s.bresp   = rst_n ? resp : OKAY;

  assign rd_en     = rst_n & (state == RD_ACCESS);
  assign wr_en     = rst_n & (state == WR_ACCESS);
  assign addr      = rst_n ? acc_addr : '0;
  assign wr_data   = rst_n ? w_data : '0;
  assign wr_strobe = rst_n ? w_strb : '0;

endmodule

// File: tb/tb_axi4_lite_subordinate.sv
// Scoreboard bench: stimulus pushes expected R/B beats and local
// accesses; a negedge monitor pops and compares as they appear.
module tb_axi4_lite_subordinate;
  import rv32::*;

  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'h1000;
  localparam longint unsigned REGION = 'h100;
  localparam int          TO   = 16;

  typedef struct {
    word        d;
    logic [1:0] r;
  } rexp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    word         d;
    logic [3:0]  s;
    int          len;
  } lexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_lite #(.ADDR_WIDTH(AW)) bus ();

  logic          rd_en;
  logic          wr_en;
  logic [AW-1:0] addr;
  word           wr_data;
  logic [3:0]    wr_strobe;
  word           rd_data;
  logic          ready;
  logic          fault;

  axi4_lite_subordinate #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE),
    .REGION_SIZE(REGION),
    .TIMEOUT    (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .axi_s    (bus),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .wr_strobe(wr_strobe),
    .rd_data  (rd_data),
    .ready    (ready),
    .fault    (fault)
  );

  rexp_t      rq[$];
  logic [1:0] bq[$];
  lexp_t      lq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   r_beats = 0;
  int   b_beats = 0;
  int   rv_rise_cyc = 0;
  int   ar_hs_cyc = 0;
  int   stab_viol = 0;
  int   r_stall = 0;
  int   w_viol = 0;
  int   l_instab = 0;
  logic watch_w = 1'b0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: R/B scoreboards, handshake stability, local access log.
  initial begin : monitor
    logic        rv_prev = 1'b0;
    logic        r_hs_prev = 1'b0;
    word         rd_prev = '0;
    logic [1:0]  rr_prev = '0;
    logic        bv_prev = 1'b0;
    logic        b_hs_prev = 1'b0;
    logic [1:0]  br_prev = '0;
    logic        lact = 1'b0;
    lexp_t       cur;
    rexp_t       re;
    lexp_t       le;
    logic [1:0]  be;
    cur = '{1'b0, 32'h0, 32'h0, 4'h0, 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rv_prev = 1'b0;
        bv_prev = 1'b0;
        lact    = 1'b0;
        watch_w = 1'b0;
      end else begin
        if (bus.rvalid) begin
          if (rv_prev && !r_hs_prev &&
              (bus.rdata !== rd_prev || bus.rresp !== rr_prev))
            stab_viol++;
          if (!rv_prev || r_hs_prev) rv_rise_cyc = cyc;
          if (!bus.rready) r_stall++;
        end else if (rv_prev && !r_hs_prev) begin
          stab_viol++;
        end
        if (bus.rvalid && bus.rready) begin
          r_beats++;
          checks++;
          if (rq.size() == 0) begin
            errors++;
            $display("FAIL r_unexpected: got rdata %0h rresp %0d expected none",
                     bus.rdata, bus.rresp);
          end else begin
            re = rq.pop_front();
            if (bus.rdata !== re.d || bus.rresp !== re.r) begin
              errors++;
              $display("FAIL r_beat: got rdata %0h rresp %0d expected %0h %0d",
                       bus.rdata, bus.rresp, re.d, re.r);
            end
          end
        end
        rv_prev   = bus.rvalid;
        r_hs_prev = bus.rvalid && bus.rready;
        rd_prev   = bus.rdata;
        rr_prev   = bus.rresp;

        if (bus.bvalid && bv_prev && !b_hs_prev && bus.bresp !== br_prev)
          stab_viol++;
        if (!bus.bvalid && bv_prev && !b_hs_prev) stab_viol++;
        if (watch_w && bus.wready) w_viol++;
        if (bus.bvalid && bus.bready) begin
          b_beats++;
          watch_w = 1'b0;
          checks++;
          if (bq.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected: got bresp %0d expected none", bus.bresp);
          end else begin
            be = bq.pop_front();
            if (bus.bresp !== be) begin
              errors++;
              $display("FAIL b_beat: got bresp %0d expected %0d", bus.bresp, be);
            end
          end
        end
        bv_prev   = bus.bvalid;
        b_hs_prev = bus.bvalid && bus.bready;
        br_prev   = bus.bresp;

        if ((rd_en || wr_en) && !lact) begin
          lact = 1'b1;
          cur  = '{wr_en, addr, wr_data, wr_strobe, 1};
        end else if ((rd_en || wr_en) && lact) begin
          cur.len++;
          if (addr !== cur.a || (cur.w && wr_data !== cur.d)) l_instab++;
        end else if (lact) begin
          lact = 1'b0;
          checks++;
          if (lq.size() == 0) begin
            errors++;
            $display("FAIL local_unexpected: got w=%0d addr %0h len %0d expected none",
                     cur.w, cur.a, cur.len);
          end else begin
            le = lq.pop_front();
            if (cur.w !== le.w || cur.a !== le.a || cur.len != le.len ||
                (le.w && (cur.d !== le.d || cur.s !== le.s))) begin
              errors++;
              $display("FAIL local_access: got w=%0d a=%0h d=%0h s=%0h len=%0d expected w=%0d a=%0h d=%0h s=%0h len=%0d",
                       cur.w, cur.a, cur.d, cur.s, cur.len,
                       le.w, le.a, le.d, le.s, le.len);
            end
          end
        end
      end
    end
  end

  task automatic issue(input bit do_ar, input bit do_aw, input bit do_w,
                       input logic [31:0] ara, input logic [31:0] awa,
                       input word wd, input logic [3:0] ws);
    logic ha, hb, hc;
    bus.arvalid = do_ar;
    bus.araddr  = ara;
    bus.awvalid = do_aw;
    bus.awaddr  = awa;
    bus.wvalid  = do_w;
    bus.wdata   = wd;
    bus.wstrb   = ws;
    for (int i = 0; i < 200 && (bus.arvalid || bus.awvalid || bus.wvalid); i++) begin
      ha = bus.arvalid & bus.arready;
      hb = bus.awvalid & bus.awready;
      hc = bus.wvalid & bus.wready;
      if (ha) ar_hs_cyc = cyc;
      step();
      if (ha) bus.arvalid = 1'b0;
      if (hb) bus.awvalid = 1'b0;
      if (hc) bus.wvalid = 1'b0;
    end
    chk("issue_handshake", {bus.arvalid, bus.awvalid, bus.wvalid}, 3'b000);
    bus.arvalid = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  task automatic wait_beats(input int rt, input int bt);
    for (int i = 0; i < 300 && (r_beats < rt || b_beats < bt); i++) step();
    chk("beat_wait", {r_beats >= rt, b_beats >= bt}, 2'b11);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid,
               bus.rdata, bus.rresp, bus.bresp, rd_en, wr_en, addr,
               wr_data, wr_strobe}, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin : stim
    int rb;
    int stall0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
    bus.rready  = 1'b1; bus.bready = 1'b1;
    rd_data = 32'hDEADBEEF;
    ready   = 1'b1;
    fault   = 1'b0;

    step();
    step();
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    step();
    chk("readies_after_reset", {bus.arready, bus.awready, bus.wready}, 3'b111);

    // Zero-wait read
    rq.push_back('{32'hDEADBEEF, 2'd0});
    lq.push_back('{1'b0, 32'h004, 32'h0, 4'h0, 1});
    issue(1, 0, 0, 32'h1004, 0, 0, 0);
    wait_beats(1, 0);
    chk("read_latency", 32'(rv_rise_cyc - ar_hs_cyc), 32'd3);

    // W before AW
    bq.push_back(2'd0);
    lq.push_back('{1'b1, 32'h008, 32'h12345678, 4'b0011, 1});
    issue(0, 0, 1, 0, 0, 32'h12345678, 4'b0011);
    watch_w = 1'b1;
    step();
    issue(0, 1, 0, 0, 32'h1008, 0, 0);
    wait_beats(1, 1);
    chk("wready_held_low", 32'(w_viol), 32'd0);

    // Decode misses
    rq.push_back('{32'h0, 2'd3});
    issue(1, 0, 0, 32'h2000, 0, 0, 0);
    wait_beats(2, 1);
    bq.push_back(2'd3);
    issue(0, 1, 1, 0, 32'h0FFC, 32'hAAAA5555, 4'hF);
    wait_beats(2, 2);
    chk("decerr_no_local", 32'(lq.size()), 32'd0);

    // Timeout then fault
    ready = 1'b0;
    rq.push_back('{32'h0, 2'd2});
    lq.push_back('{1'b0, 32'h00C, 32'h0, 4'h0, TO + 1});
    issue(1, 0, 0, 32'h100C, 0, 0, 0);
    wait_beats(3, 2);
    ready = 1'b1;
    fault = 1'b1;
    bq.push_back(2'd2);
    lq.push_back('{1'b1, 32'h010, 32'h0BADF00D, 4'hF, 1});
    issue(0, 1, 1, 0, 32'h1010, 32'h0BADF00D, 4'hF);
    wait_beats(3, 3);
    fault = 1'b0;

    // Simultaneous AR/AW/W after reset: read first, held 5 cycles
    do_reset();
    bus.rready = 1'b0;
    rd_data = 32'h11112222;
    rq.push_back('{32'h11112222, 2'd0});
    bq.push_back(2'd0);
    lq.push_back('{1'b0, 32'h020, 32'h0, 4'h0, 1});
    lq.push_back('{1'b1, 32'h024, 32'hCAFEF00D, 4'hF, 1});
    stall0 = r_stall;
    issue(1, 1, 1, 32'h1020, 32'h1024, 32'hCAFEF00D, 4'hF);
    for (int i = 0; i < 50 && !bus.rvalid; i++) step();
    chk("rvalid_seen", bus.rvalid, 1'b1);
    repeat (5) step();
    bus.rready = 1'b1;
    wait_beats(4, 4);
    chk("r_stall_cycles", 32'(r_stall - stall0), 32'd5);
    chk("resp_stability", 32'(stab_viol), 32'd0);

    // A read, then a contended pair goes write-first
    rd_data = 32'h33334444;
    rq.push_back('{32'h33334444, 2'd0});
    lq.push_back('{1'b0, 32'h028, 32'h0, 4'h0, 1});
    issue(1, 0, 0, 32'h1028, 0, 0, 0);
    wait_beats(5, 4);
    rq.push_back('{32'h33334444, 2'd0});
    bq.push_back(2'd0);
    lq.push_back('{1'b1, 32'h034, 32'h55AA55AA, 4'h5, 1});
    lq.push_back('{1'b0, 32'h030, 32'h0, 4'h0, 1});
    issue(1, 1, 1, 32'h1030, 32'h1034, 32'h55AA55AA, 4'h5);
    wait_beats(6, 5);

    // Reset mid-access
    ready = 1'b0;
    issue(1, 0, 0, 32'h1040, 0, 0, 0);
    for (int i = 0; i < 20 && !rd_en; i++) step();
    chk("rd_en_before_reset", rd_en, 1'b1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk_zero("reset_mid_access");
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("readies_after_abort", {bus.arready, bus.awready, bus.wready}, 3'b111);
    rb = r_beats;
    ready = 1'b1;
    repeat (20) step();
    chk("no_r_after_abort", 32'(r_beats), 32'(rb));

    chk("local_addr_stable", 32'(l_instab), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    chk("bq_empty", 32'(bq.size()), 32'd0);
    chk("lq_empty", 32'(lq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
